// File: rtl/queue_pkg.sv
// Shared types and sizing defaults for the queue memory buffer and its readers.
package queue_pkg;

  localparam int QUEUE_DATA_WIDTH = 8;
  localparam int QUEUE_MAX_DEPTH  = 16;

  typedef enum logic [1:0] {QR_IDLE, QR_FETCH, QR_FLUSH, QR_DONE} qr_state_t;

endpackage

// File: rtl/queue_burst_reader_out_buf.sv
// Purpose: 2-entry {last,data} FIFO whose head register drives the output stream directly.
// Latency: a push is visible at the head the cycle after it is written into an empty buffer.
// Backpressure: head holds until pop; push and pop in one cycle keep occupancy unchanged.
module qbr_out_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] slot1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data <= '0;
      slot1     <= '0;
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) head_data <= push_data;
          else                   slot1     <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head_data <= slot1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Pop is only ever asserted with a valid head, so occupancy is 1 or 2 here.
          if (occupancy == 2'd2) begin
            head_data <= slot1;
            slot1     <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (occupancy != 2'd0);

endmodule

// File: rtl/queue_burst_reader.sv
// Purpose: reads a burst of req_len words from the queue buffer and streams them out with m_last.
// Latency: first m_valid two edges after the accept edge (rd_en, then capture); 1 word/cycle after.
// Backpressure: m_ready stalls hold the head; reads stop once buffered + in-flight words reach 2.
module queue_burst_reader
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = QUEUE_DATA_WIDTH,
  parameter int MAX_BURST  = QUEUE_MAX_DEPTH,
  parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [LEN_W-1:0]      req_len,
  output logic                  req_ready,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  qr_state_t             state;
  logic [LEN_W-1:0]      remaining;
  logic [LEN_W-1:0]      len_clamped;
  logic                  inflight;
  logic                  inflight_last;
  logic                  pop;
  logic                  head_valid;
  logic [DATA_WIDTH:0]   head;
  logic [1:0]            occupancy;
  logic [1:0]            committed;

  assign len_clamped = (req_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : req_len;
  assign pop         = head_valid && m_ready;
  assign committed   = occupancy + {1'b0, inflight};

  // A head leaving this cycle frees a slot, which keeps reads back-to-back at full rate.
  assign rd_en = (state == QR_FETCH) && !rd_empty && (remaining != '0) &&
                 ((committed < 2'd2) || (pop && (committed == 2'd2)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= QR_IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (remaining == LEN_W'(1));
      case (state)
        QR_IDLE: begin
          if (req_valid) begin
            if (len_clamped == '0) begin
              state <= QR_DONE;
            end else begin
              state     <= QR_FETCH;
              remaining <= len_clamped;
            end
          end
        end
        QR_FETCH: begin
          if (rd_en) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= QR_FLUSH;
          end
        end
        QR_FLUSH: begin
          if (pop && head[DATA_WIDTH]) state <= QR_DONE;
        end
        QR_DONE: state <= QR_IDLE;
        default: state <= QR_IDLE;
      endcase
    end
  end

  qbr_out_buf #(.W(DATA_WIDTH + 1)) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_data  ({inflight_last, rd_data}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head),
    .occupancy  (occupancy)
  );

  assign m_valid   = head_valid;
  assign m_data    = head[DATA_WIDTH-1:0];
  assign m_last    = head[DATA_WIDTH];
  assign req_ready = (state == QR_IDLE);
  assign busy      = (state != QR_IDLE);
  assign done      = (state == QR_DONE);

endmodule

// File: tb/tb_queue_burst_reader.sv
// Directed bench: a small queue model feeds the read port, a per-cycle monitor collects the stream.
module tb_queue_burst_reader;

  localparam int DW    = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             rd_en;
  logic [DW-1:0]    rd_data;
  logic             rd_empty;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  queue_burst_reader #(.DATA_WIDTH(DW), .MAX_BURST(16), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic [7:0] mem_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_q[$];
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic       last_acc = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_head = 9'h0;

  int rd_en_cnt = 0, done_cnt = 0, acc_cnt = 0, acc_cyc = 0, done_cyc = 0;
  int fv_cyc = -1, first_hs = -1, last_hs = -1, out_cnt = 0, max_out = 0;
  int stab_err = 0, empty_err = 0, overlap_err = 0;
  int dc_save = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, settle, then observe the DUT.
  task automatic tick(input logic rv, input logic [LEN_W-1:0] rl, input logic mr);
    @(negedge clk);
    if (pend) begin
      rd_data = pend_data;
      pend    = 1'b0;
    end
    rd_empty  = (mem_q.size() == 0);
    req_valid = rv;
    req_len   = rl;
    m_ready   = mr;
    #1;
    cyc_n++;
    last_acc = rv && (req_ready === 1'b1) && rst_n;
    if (last_acc) begin
      acc_cnt++;
      acc_cyc = cyc_n;
    end
    if (busy === 1'b1 && req_ready === 1'b1) overlap_err++;
    if (prev_stall && (m_valid !== 1'b1 || {m_last, m_data} !== prev_head)) stab_err++;
    prev_stall = (m_valid === 1'b1) && !mr;
    prev_head  = {m_last, m_data};
    if (m_valid === 1'b1 && fv_cyc < 0) fv_cyc = cyc_n;
    if (rd_en === 1'b1) begin
      if (rd_empty) empty_err++;
      if (mem_q.size() != 0) pend_data = mem_q.pop_front();
      else                   pend_data = 8'h00;
      pend = 1'b1;
      rd_en_cnt++;
      out_cnt++;
    end
    if (m_valid === 1'b1 && mr) begin
      got_q.push_back(m_data);
      if (m_last) last_q.push_back(m_data);
      if (first_hs < 0) first_hs = cyc_n;
      last_hs = cyc_n;
      out_cnt--;
    end
    if (out_cnt > max_out) max_out = out_cnt;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  task automatic clear_stats();
    got_q.delete();
    last_q.delete();
    rd_en_cnt = 0;
    done_cnt  = 0;
    fv_cyc    = -1;
    first_hs  = -1;
    last_hs   = -1;
    out_cnt   = 0;
    max_out   = 0;
  endtask

  task automatic prefill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) mem_q.push_back(8'(base + 8'(i)));
  endtask

  task automatic burst(input string tag, input logic [LEN_W-1:0] len, input bit toggle,
                       input bit hold, input int trickle_n, input logic [7:0] trickle_base);
    int written = 0;
    clear_stats();
    tick(1'b1, len, 1'b1);
    chk({tag, "_accept"}, 32'(last_acc), 32'd1);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      if (written < trickle_n && (i % 3) == 0) begin
        mem_q.push_back(8'(trickle_base + 8'(written)));
        written++;
      end
      tick(hold, len, toggle ? i[0] : 1'b1);
    end
    if (!hold) tick(1'b0, '0, 1'b1);
  endtask

  task automatic verify(input string tag, input logic [7:0] base, input int n);
    int bad = 0;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== 8'(base + 8'(i))) bad++;
    chk({tag, "_order"}, 32'(bad), 32'd0);
    chk({tag, "_last_count"}, 32'(last_q.size()), 32'd1);
    if (last_q.size() == 1) chk({tag, "_last_word"}, 32'(last_q[0]), 32'(8'(base + 8'(n - 1))));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_rd_en_count"}, 32'(rd_en_cnt), 32'(n));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
    chk({tag, "_m_valid"},   32'(m_valid),   32'd0);
    chk({tag, "_m_last"},    32'(m_last),    32'd0);
    chk({tag, "_m_data"},    32'(m_data),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_len   = '0;
    m_ready   = 1'b0;
    rd_data   = '0;
    rd_empty  = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check_reset("rst");
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b1);

    // 1: four prefilled words at full rate
    prefill(8'hA0, 4);
    burst("t1", 5'd4, 1'b0, 1'b0, 0, 8'h00);
    verify("t1", 8'hA0, 4);
    chk("t1_first_valid_delay", 32'(fv_cyc - acc_cyc), 32'd3);
    chk("t1_consecutive", 32'(last_hs - first_hs), 32'd3);
    chk("t1_idle_ready", 32'(req_ready), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: sixteen words with m_ready toggling
    prefill(8'h10, 16);
    burst("t2", 5'd16, 1'b1, 1'b0, 0, 8'h00);
    verify("t2", 8'h10, 16);
    chk("t2_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("t2_head_stable", 32'(stab_err), 32'd0);

    // 3: empty buffer, words trickle in every third cycle
    burst("t3", 5'd3, 1'b0, 1'b0, 3, 8'hB0);
    verify("t3", 8'hB0, 3);
    chk("t3_rd_en_when_empty", 32'(empty_err), 32'd0);

    // 4: zero-length request
    clear_stats();
    tick(1'b1, 5'd0, 1'b1);
    chk("t4_accept", 32'(last_acc), 32'd1);
    tick(1'b0, '0, 1'b1);
    chk("t4_done_next", 32'(done), 32'd1);
    chk("t4_busy_in_done", 32'(busy), 32'd1);
    tick(1'b0, '0, 1'b1);
    chk("t4_done_one_cycle", 32'(done), 32'd0);
    chk("t4_back_idle", 32'(req_ready), 32'd1);
    chk("t4_no_rd_en", 32'(rd_en_cnt), 32'd0);
    chk("t4_no_valid", 32'(fv_cyc), 32'hFFFF_FFFF);

    // 5: reset in the middle of a toggled 16-word burst, then a fresh 2-word burst
    prefill(8'h60, 16);
    clear_stats();
    tick(1'b1, 5'd16, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, '0, i[0]);
    done_cnt = 0;
    rst_n = 1'b0;
    tick(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    mem_q.delete();
    pend       = 1'b0;
    prev_stall = 1'b0;
    out_cnt    = 0;
    tick(1'b0, '0, 1'b1);
    check_reset("t5_rst");
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    prefill(8'hC0, 2);
    burst("t5", 5'd2, 1'b0, 1'b0, 0, 8'h00);
    verify("t5", 8'hC0, 2);

    // 6: request held high through the burst
    prefill(8'hD0, 6);
    acc_cnt = 0;
    overlap_err = 0;
    burst("t6a", 5'd3, 1'b0, 1'b1, 0, 8'h00);
    verify("t6a", 8'hD0, 3);
    chk("t6_single_accept", 32'(acc_cnt), 32'd1);
    dc_save = done_cyc;
    burst("t6b", 5'd3, 1'b0, 1'b1, 0, 8'h00);
    chk("t6_accept_after_done", 32'(acc_cyc - dc_save), 32'd1);
    verify("t6b", 8'hD3, 3);
    tick(1'b0, '0, 1'b1);
    chk("t6_two_accepts", 32'(acc_cnt), 32'd2);
    chk("t6_no_overlap", 32'(overlap_err), 32'd0);

    // 7: oversize request is clamped to the maximum burst
    prefill(8'h40, 20);
    burst("t7", 5'd20, 1'b0, 1'b0, 0, 8'h00);
    verify("t7", 8'h40, 16);
    chk("t7_left_in_queue", 32'(mem_q.size()), 32'd4);
    mem_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
